// File: rtl/testing_cpu_mul_seq.sv
// testing_cpu_mul_seq: two-pass multiply sequencer in front of the CPU multiply cell.
// The cell alone leaves out the a_lo*b_hi cross term. This block runs the cell twice
// and adds the two passes to form (a*b) mod 2^32.
// Optional feature macro: TESTING_CPU_MUL_SEQ_FLUSH_EN adds a synchronous flush/abort input.
module testing_cpu_mul_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] M_mul_src1,
  output logic [31:0] M_mul_src2,
  input  logic [31:0] M_mul_cell_result
`ifdef TESTING_CPU_MUL_SEQ_FLUSH_EN
  ,
  input  logic        flush
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    SUM   = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] a_reg, a_next;          // multiplicand, becomes pass-2 operand 2
  logic [15:0] b_hi_reg, b_hi_next;    // only the upper half of b is needed after pass 1 is issued
  logic [31:0] src1_reg, src1_next;
  logic [31:0] src2_reg, src2_next;
  logic [31:0] partial_reg, partial_next;
  logic [31:0] result_reg, result_next;
  logic        done_reg, done_next;

  // State and datapath registers; everything clears on reset, including a request in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      a_reg       <= 32'd0;
      b_hi_reg    <= 16'd0;
      src1_reg    <= 32'd0;
      src2_reg    <= 32'd0;
      partial_reg <= 32'd0;
      result_reg  <= 32'd0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      a_reg       <= a_next;
      b_hi_reg    <= b_hi_next;
      src1_reg    <= src1_next;
      src2_reg    <= src2_next;
      partial_reg <= partial_next;
      result_reg  <= result_next;
      done_reg    <= done_next;
    end
  end

  // Next-state and datapath control; every register holds unless its state updates it.
  always_comb begin
    state_next   = state_reg;
    a_next       = a_reg;
    b_hi_next    = b_hi_reg;
    src1_next    = src1_reg;
    src2_next    = src2_reg;
    partial_next = partial_reg;
    result_next  = result_reg;
    done_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          a_next     = src1;
          b_hi_next  = src2[31:16];
          src1_next  = src1;
          src2_next  = src2;
          state_next = PASS1;
        end
      end
      PASS1: begin
        // Second pass puts b_hi into the cell's x_hi slot so the cell returns (b_hi*a_lo)<<16.
        src1_next  = {b_hi_reg, 16'h0000};
        src2_next  = a_reg;
        state_next = PASS2;
      end
      PASS2: begin
        // The cell output now reflects the pass-1 operands.
        partial_next = M_mul_cell_result;
        state_next   = SUM;
      end
      SUM: begin
        result_next = partial_reg + M_mul_cell_result;
        done_next   = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase

`ifdef TESTING_CPU_MUL_SEQ_FLUSH_EN
    // Flush wins over everything, including a start in IDLE: no state other than the FSM moves.
    if (flush) begin
      state_next   = IDLE;
      a_next       = a_reg;
      b_hi_next    = b_hi_reg;
      src1_next    = src1_reg;
      src2_next    = src2_reg;
      partial_next = partial_reg;
      result_next  = result_reg;
      done_next    = 1'b0;
    end
`endif
  end

  assign busy       = (state_reg != IDLE);
  assign done       = done_reg;
  assign result     = result_reg;
  assign M_mul_src1 = src1_reg;
  assign M_mul_src2 = src2_reg;

endmodule

// File: tb/tb_testing_cpu_mul_seq.sv
// Testbench for testing_cpu_mul_seq: cell model, table-driven vectors, directed
// corner sequences, and randomized traffic against a latency/product reference model.
module tb_testing_cpu_mul_seq;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] M_mul_src1;
  logic [31:0] M_mul_src2;
  logic [31:0] M_mul_cell_result;
  logic        flush;

  int n_checks = 0;
  int n_fail   = 0;

  testing_cpu_mul_seq dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .src1              (src1),
    .src2              (src2),
    .busy              (busy),
    .done              (done),
    .result            (result),
    .M_mul_src1        (M_mul_src1),
    .M_mul_src2        (M_mul_src2),
    .M_mul_cell_result (M_mul_cell_result)
`ifdef TESTING_CPU_MUL_SEQ_FLUSH_EN
    ,
    .flush             (flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiply cell model: one register stage on the operands, combinational output.
  logic [31:0] cell_x, cell_y;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cell_x <= 32'd0;
      cell_y <= 32'd0;
    end else begin
      cell_x <= M_mul_src1;
      cell_y <= M_mul_src2;
    end
  end
  assign M_mul_cell_result = (cell_x[15:0] * cell_y[15:0]) + ((cell_x[31:16] * cell_y[15:0]) << 16);

  // Reference model: a request takes 4 cycles; result is the plain 32-bit product.
  int          rem_m;
  bit          done_m;
  logic [31:0] res_m;
  logic [31:0] prod_m;

  task automatic model_reset();
    rem_m  = 0;
    done_m = 0;
    res_m  = 32'd0;
    prod_m = 32'd0;
  endtask

  task automatic model_edge(input bit st, input logic [31:0] a, input logic [31:0] b, input bit fl);
    if (!reset_n) begin
      model_reset();
    end else if (fl) begin
      rem_m  = 0;
      done_m = 0;
    end else begin
      done_m = 0;
      if (rem_m == 0) begin
        if (st) begin
          rem_m  = 3;
          prod_m = a * b;
        end
      end else begin
        rem_m = rem_m - 1;
        if (rem_m == 0) begin
          done_m = 1;
          res_m  = prod_m;
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, update model at posedge, sample 1 time unit later.
  task automatic cycle(input bit st, input logic [31:0] a, input logic [31:0] b, input bit fl);
    @(negedge clk);
    start = st;
    src1  = a;
    src2  = b;
`ifdef TESTING_CPU_MUL_SEQ_FLUSH_EN
    flush = fl;
`else
    flush = 1'b0;
`endif
    @(posedge clk);
    model_edge(st, a, b, flush);
    #1;
    check("busy", {31'd0, busy}, {31'd0, rem_m != 0});
    check("done", {31'd0, done}, {31'd0, done_m});
    check("result", result, res_m);
    $display("cyc st=%0b a=%h b=%h fl=%0b -> busy=%0b done=%0b result=%h", st, a, b, flush, busy, done, result);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{32'h00010002, 32'h00030004, 32'h000A0008};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    vecs[2] = '{32'h12345678, 32'h00000000, 32'h00000000};
    vecs[3] = '{32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001};
    vecs[4] = '{32'h00010000, 32'h00010000, 32'h00000000};
    vecs[5] = '{32'h80000001, 32'h00000003, 32'h80000003};

    reset_n = 1'b0;
    start   = 1'b0;
    src1    = 32'd0;
    src2    = 32'd0;
    flush   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_src1", M_mul_src1, 32'd0);
    check("rst_src2", M_mul_src2, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cycle(0, 32'd0, 32'd0, 0);

    // Operand sequencing on the cell interface.
    cycle(1, 32'h00010002, 32'h00030004, 0);
    check("c1_src1", M_mul_src1, 32'h00010002);
    check("c1_src2", M_mul_src2, 32'h00030004);
    cycle(0, 32'hDEADBEEF, 32'hCAFEF00D, 0);
    check("c2_src1", M_mul_src1, 32'h00030000);
    check("c2_src2", M_mul_src2, 32'h00010002);
    cycle(0, 32'd0, 32'd0, 0);
    cycle(0, 32'd0, 32'd0, 0);
    check("c4_done", {31'd0, done}, 32'd1);
    check("c4_result", result, 32'h000A0008);
    cycle(0, 32'd0, 32'd0, 0);
    check("c5_src_hold", M_mul_src1, 32'h00030000);

    // Table-driven vectors; operands are scrambled after the accepting edge.
    for (int i = 0; i < 6; i++) begin
      cycle(1, vecs[i].a, vecs[i].b, 0);
      for (int k = 0; k < 3; k++) cycle(0, $urandom, $urandom, 0);
      check($sformatf("vec%0d_done", i), {31'd0, done}, 32'd1);
      check($sformatf("vec%0d_result", i), result, vecs[i].exp);
      cycle(0, 32'd0, 32'd0, 0);
    end

    // Back-to-back with an ignored start in cycle 2.
    cycle(1, 32'd3, 32'd5, 0);
    cycle(0, 32'd0, 32'd0, 0);
    cycle(1, 32'd100, 32'd100, 0);
    cycle(0, 32'd0, 32'd0, 0);
    check("b2b_done1", {31'd0, done}, 32'd1);
    check("b2b_res1", result, 32'd15);
    cycle(1, 32'd7, 32'd9, 0);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    cycle(0, 32'd0, 32'd0, 0);
    cycle(0, 32'd0, 32'd0, 0);
    cycle(0, 32'd0, 32'd0, 0);
    check("b2b_done2", {31'd0, done}, 32'd1);
    check("b2b_res2", result, 32'd63);
    cycle(0, 32'd0, 32'd0, 0);

    // Asynchronous reset in cycle 2 of a request.
    cycle(1, 32'h00001234, 32'h00005678, 0);
    cycle(0, 32'd0, 32'd0, 0);
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_result", result, 32'd0);
    check("arst_src1", M_mul_src1, 32'd0);
    check("arst_src2", M_mul_src2, 32'd0);
    cycle(0, 32'd0, 32'd0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    cycle(1, 32'h00001234, 32'h00005678, 0);
    for (int k = 0; k < 3; k++) cycle(0, 32'd0, 32'd0, 0);
    check("post_rst_res", result, 32'h06260060);

`ifdef TESTING_CPU_MUL_SEQ_FLUSH_EN
    // Flush in cycle 2 aborts; result keeps the previous value.
    cycle(1, 32'd11, 32'd13, 0);
    cycle(0, 32'd0, 32'd0, 0);
    cycle(0, 32'd0, 32'd0, 1);
    check("fl_busy", {31'd0, busy}, 32'd0);
    cycle(0, 32'd0, 32'd0, 0);
    cycle(0, 32'd0, 32'd0, 0);
    check("fl_result", result, 32'h06260060);
    // Flush together with start in IDLE: not accepted.
    cycle(1, 32'd2, 32'd2, 1);
    check("flst_busy", {31'd0, busy}, 32'd0);
    cycle(0, 32'd0, 32'd0, 0);
`endif

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 2) == 0), $urandom, $urandom, ($urandom_range(0, 15) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
